// File: rtl/sysrow_pkg.sv
// rtl/sysrow_pkg.sv - shared state enum, datapath widths and width helpers for the SysRow sequencer
package sysrow_pkg;

    localparam int DATA_W = 8;
    localparam int SUM_W  = 16;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_STREAM,
        ST_DRAIN,
        ST_DONE
    } seq_state_e;

    function automatic int w_bits(input int cells);
        return DATA_W * cells;
    endfunction

    function automatic int sum_bits(input int cells);
        return SUM_W * cells;
    endfunction

    // Width of a counter that runs 0 .. cells-1
    function automatic int cnt_bits(input int cells);
        return (cells < 2) ? 1 : $clog2(cells);
    endfunction

endpackage

// File: rtl/sysrow_deskew.sv
// rtl/sysrow_deskew.sv - per-column delay lines and valid shift register that realign SysRow outputs
module sysrow_deskew
    import sysrow_pkg::*;
#(
    parameter int ROW_WIDTH = 4
)
(
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          in_valid,
    input  logic [SUM_W*ROW_WIDTH-1:0]    mac_in,
    output logic [SUM_W*ROW_WIDTH-1:0]    res,
    output logic                          res_valid
);

    logic [ROW_WIDTH-1:0]       vld_q;
    logic [ROW_WIDTH-1:0]       vld_d;
    logic [SUM_W*ROW_WIDTH-1:0] tap;

    // Valid follows the word through ROW_WIDTH stages, matching the slowest column
    always_comb begin
        vld_d = (vld_q << 1) | ROW_WIDTH'(in_valid);
    end

    // Valid pipeline register
    always_ff @(posedge clk) begin
        if (!rst_n) vld_q <= '0;
        else        vld_q <= vld_d;
    end

    // Column k arrives k+1 cycles after transfer, so it waits ROW_WIDTH-1-k more
    for (genvar k = 0; k < ROW_WIDTH; k++) begin : g_col
        localparam int DLY = ROW_WIDTH - 1 - k;
        if (DLY == 0) begin : g_pass
            assign tap[k*SUM_W +: SUM_W] = mac_in[k*SUM_W +: SUM_W];
        end else begin : g_dly
            logic [SUM_W-1:0] line_q [DLY];
            logic [SUM_W-1:0] line_d [DLY];

            // Shift the column's partial result one slot per cycle
            always_comb begin
                line_d[0] = mac_in[k*SUM_W +: SUM_W];
                for (int i = 1; i < DLY; i++) line_d[i] = line_q[i-1];
            end

            // Delay-line register
            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    for (int i = 0; i < DLY; i++) line_q[i] <= '0;
                end else begin
                    line_q <= line_d;
                end
            end

            assign tap[k*SUM_W +: SUM_W] = line_q[DLY-1];
        end
    end

    assign res_valid = vld_q[ROW_WIDTH-1];
    // Zero when idle so stale or unknown SysRow values never reach the consumer
    assign res       = res_valid ? tap : '0;

endmodule

// File: rtl/sysrow_seq.sv
// rtl/sysrow_seq.sv - job sequencer driving one SysRow; optional perf counter under SYSROW_SEQ_PERF_EN
module sysrow_seq
    import sysrow_pkg::*;
#(
    parameter int ROW_WIDTH = 4,
    parameter int LEN_W     = 8
)
(
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          start,
    input  logic [LEN_W-1:0]              len,
    input  logic [DATA_W*ROW_WIDTH-1:0]   weights,
    input  logic [SUM_W*ROW_WIDTH-1:0]    bias,
    input  logic [DATA_W-1:0]             din,
    input  logic                          din_valid,
    output logic                          din_ready,
    output logic                          row_active,
    output logic [DATA_W-1:0]             row_data,
    output logic [DATA_W*ROW_WIDTH-1:0]   row_w,
    output logic [ROW_WIDTH-1:0]          row_wren,
    output logic [SUM_W*ROW_WIDTH-1:0]    row_sum,
    input  logic [SUM_W*ROW_WIDTH-1:0]    row_mac,
    output logic [SUM_W*ROW_WIDTH-1:0]    res,
    output logic                          res_valid,
    output logic                          busy,
    output logic                          done,
    output logic [31:0]                   perf_cycles
);

    localparam int WW = w_bits(ROW_WIDTH);
    localparam int SW = sum_bits(ROW_WIDTH);
    localparam int CW = cnt_bits(ROW_WIDTH);
    localparam logic [CW-1:0] DRAIN_LAST = CW'(ROW_WIDTH - 1);

    seq_state_e       state_q, state_d;
    logic [LEN_W-1:0] rem_q, rem_d;
    logic [WW-1:0]    w_q, w_d;
    logic [SW-1:0]    bias_q, bias_d;
    logic [CW-1:0]    drain_q, drain_d;
    logic             xfer;

    // Next-state, captured job parameters and SysRow weight-load controls
    always_comb begin
        state_d   = state_q;
        rem_d     = rem_q;
        w_d       = w_q;
        bias_d    = bias_q;
        drain_d   = drain_q;
        din_ready = 1'b0;
        row_wren  = '0;
        row_w     = '0;
        xfer      = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_LOAD;
                    rem_d   = len;
                    w_d     = weights;
                    bias_d  = bias;
                end
            end
            ST_LOAD: begin
                row_wren = '1;
                row_w    = w_q;
                drain_d  = '0;
                state_d  = (rem_q == '0) ? ST_DRAIN : ST_STREAM;
            end
            ST_STREAM: begin
                din_ready = (rem_q != '0);
                xfer      = din_valid && din_ready;
                if (xfer) begin
                    rem_d = rem_q - LEN_W'(1);
                    if (rem_q == LEN_W'(1)) state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                drain_d = drain_q + CW'(1);
                if (drain_q == DRAIN_LAST) state_d = ST_DONE;
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Sequencer state and captured registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            rem_q   <= '0;
            w_q     <= '0;
            bias_q  <= '0;
            drain_q <= '0;
        end else begin
            state_q <= state_d;
            rem_q   <= rem_d;
            w_q     <= w_d;
            bias_q  <= bias_d;
            drain_q <= drain_d;
        end
    end

    assign busy       = (state_q != ST_IDLE);
    assign done       = (state_q == ST_DONE);
    assign row_active = xfer;
    assign row_data   = xfer ? din : '0;
    assign row_sum    = busy ? bias_q : '0;

    sysrow_deskew #(
        .ROW_WIDTH (ROW_WIDTH)
    ) u_deskew (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (xfer),
        .mac_in    (row_mac),
        .res       (res),
        .res_valid (res_valid)
    );

`ifdef SYSROW_SEQ_PERF_EN
    logic [31:0] perf_q, perf_d;

    // Busy-cycle count, restarted by each accepted job and held at its maximum
    always_comb begin
        perf_d = perf_q;
        if (state_q == ST_IDLE) begin
            if (start) perf_d = '0;
        end else if (perf_q != '1) begin
            perf_d = perf_q + 32'd1;
        end
    end

    // Perf counter register
    always_ff @(posedge clk) begin
        if (!rst_n) perf_q <= '0;
        else        perf_q <= perf_d;
    end

    assign perf_cycles = perf_q;
`else
    assign perf_cycles = '0;
`endif

endmodule

// File: tb/tb_sysrow_seq.sv
// tb/tb_sysrow_seq.sv - sequencer plus behavioural SysRow, checked against a job-level model
module tb_sysrow_seq;

    localparam int W = 4;

    logic        clk = 1'b0;
    logic        rst_n, start, din_valid, din_ready;
    logic [7:0]  len, din, row_data;
    logic [31:0] weights, row_w, perf_cycles;
    logic [63:0] bias, row_sum, row_mac, res;
    logic [3:0]  row_wren;
    logic        row_active, res_valid, busy, done;

    always #5 clk = ~clk;

    sysrow_seq #(.ROW_WIDTH(W), .LEN_W(8)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .len(len), .weights(weights),
        .bias(bias), .din(din), .din_valid(din_valid), .din_ready(din_ready),
        .row_active(row_active), .row_data(row_data), .row_w(row_w),
        .row_wren(row_wren), .row_sum(row_sum), .row_mac(row_mac), .res(res),
        .res_valid(res_valid), .busy(busy), .done(done), .perf_cycles(perf_cycles)
    );

    // Behavioural SysRow: each cell registers sum_in + w*x; data hops one cell per cycle
    logic [7:0]  sr_x   [W];
    logic        sr_a   [W];
    logic [7:0]  fwd_x  [W];
    logic        fwd_a  [W];
    logic [7:0]  sr_w   [W];
    logic [15:0] sr_mac [W];

    always_comb begin
        for (int k = 0; k < W; k++) begin
            sr_x[k] = (k == 0) ? row_data   : fwd_x[k-1];
            sr_a[k] = (k == 0) ? row_active : fwd_a[k-1];
            row_mac[16*k +: 16] = sr_mac[k];
        end
    end

    always @(posedge clk) begin
        for (int k = 0; k < W; k++) begin
            if (!rst_n) begin
                fwd_x[k] <= '0; fwd_a[k] <= 1'b0; sr_w[k] <= '0; sr_mac[k] <= '0;
            end else begin
                fwd_x[k] <= sr_x[k];
                fwd_a[k] <= sr_a[k];
                if (row_wren[k]) sr_w[k] <= row_w[8*k +: 8];
                if (sr_a[k]) sr_mac[k] <= row_sum[16*k +: 16] + 16'(sr_w[k]) * 16'(sr_x[k]);
            end
        end
    end

    int n_checks = 0;
    int n_err    = 0;
    int cyc      = 0;
    bit chk_en   = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [63:0] model_vec(input logic [31:0] w, input logic [63:0] b,
                                              input logic [7:0] d);
        logic [63:0] v;
        for (int k = 0; k < W; k++) v[16*k +: 16] = b[16*k +: 16] + 16'(w[8*k +: 8]) * 16'(d);
        return v;
    endfunction

    typedef struct { int cyc; logic [63:0] v; } exp_t;
    exp_t        expq[$];
    logic [63:0] log_res[$];
    int          log_cyc[$];
    int          done_cyc;

    bit          m_active = 1'b0;
    int          m_s, m_rem, m_done_at;
    logic [31:0] m_w;
    logic [63:0] m_b;
    bit          e_busy, e_load, e_ready, e_xfer, e_v, accept;

    // Job-level model: derives every expected output from the start cycle, len and transfers
    always @(negedge clk) begin
        if (chk_en) begin
            e_busy  = m_active && (cyc > m_s);
            e_load  = m_active && (cyc == m_s + 1);
            e_ready = m_active && (cyc >= m_s + 2) && (m_rem > 0);
            e_xfer  = e_ready && din_valid;
            chk("busy", 64'(busy), 64'(e_busy));
            chk("din_ready", 64'(din_ready), 64'(e_ready));
            chk("row_active", 64'(row_active), 64'(e_xfer));
            chk("row_data", 64'(row_data), e_xfer ? 64'(din) : 64'd0);
            chk("row_wren", 64'(row_wren), e_load ? 64'hF : 64'd0);
            if (e_load) chk("row_w", 64'(row_w), 64'(m_w));
            chk("row_sum", row_sum, e_busy ? m_b : 64'd0);
            chk("done", 64'(done), 64'(m_active && cyc == m_done_at));
            e_v = (expq.size() > 0) && (expq[0].cyc == cyc);
            chk("res_valid", 64'(res_valid), 64'(e_v));
            if (e_v) begin
                chk("res", res, expq[0].v);
                void'(expq.pop_front());
            end
            if (res_valid) begin
                log_res.push_back(res);
                log_cyc.push_back(cyc);
            end
            if (done) done_cyc = cyc;
            accept = start && !m_active;
            if (e_xfer) begin
                expq.push_back('{cyc + W, model_vec(m_w, m_b, din)});
                m_rem--;
                if (m_rem == 0) m_done_at = cyc + W + 1;
            end
            if (m_active && cyc == m_done_at) m_active = 1'b0;
            if (!rst_n) begin
                m_active = 1'b0;
                expq.delete();
            end else if (accept) begin
                m_active = 1'b1;
                m_s = cyc; m_rem = int'(len); m_w = weights; m_b = bias;
                if (len == 0) m_done_at = cyc + W + 2;
            end
        end
    end

    int st_cyc;
    logic [31:0] exp_perf;

    task automatic step;
        @(posedge clk); #1;
    endtask

    task automatic run_start(input logic [7:0] l, input logic [31:0] w, input logic [63:0] b);
        log_res.delete(); log_cyc.delete(); done_cyc = -1;
        len = l; weights = w; bias = b; start = 1'b1; st_cyc = cyc;
        step;
        start = 1'b0;
    endtask

    task automatic send(input logic [7:0] d);
        int g;
        g = 0;
        din = d; din_valid = 1'b1;
        while (!din_ready && g < 20) begin step; g++; end
        if (g >= 20) begin n_checks++; n_err++; $display("FAIL send_timeout: no din_ready within 20 cycles"); end
        step;
        din_valid = 1'b0; din = '0;
    endtask

    task automatic wait_done;
        int g;
        g = 0;
        while (!done && g < 60) begin step; g++; end
        if (g >= 60) begin n_checks++; n_err++; $display("FAIL done_timeout: no done within 60 cycles"); end
        step;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_busy"}, 64'(busy), 0);
        chk({tag, "_done"}, 64'(done), 0);
        chk({tag, "_ready"}, 64'(din_ready), 0);
        chk({tag, "_active"}, 64'(row_active), 0);
        chk({tag, "_data"}, 64'(row_data), 0);
        chk({tag, "_wren"}, 64'(row_wren), 0);
        chk({tag, "_w"}, 64'(row_w), 0);
        chk({tag, "_sum"}, row_sum, 0);
        chk({tag, "_res_valid"}, 64'(res_valid), 0);
        chk({tag, "_res"}, res, 0);
        chk({tag, "_perf"}, 64'(perf_cycles), 0);
    endtask

    initial begin
`ifdef SYSROW_SEQ_PERF_EN
        exp_perf = 32'd7;
`else
        exp_perf = 32'd0;
`endif
        rst_n = 1'b0; start = 1'b0; len = '0; weights = '0; bias = '0;
        din = '0; din_valid = 1'b0; done_cyc = -1;
        repeat (3) step;
        chk_all_zero("reset");
        rst_n = 1'b1; chk_en = 1'b1;
        step;

        // One word: single result, done seven cycles after start
        run_start(8'd1, 32'h44332211, 64'd0);
        send(8'h10);
        wait_done;
        chk("s1_count", 64'(log_res.size()), 64'd1);
        if (log_res.size() >= 1) begin
            chk("s1_res", log_res[0], 64'h0440_0330_0220_0110);
            chk("s1_res_cyc", 64'(log_cyc[0] - st_cyc), 64'd6);
        end
        chk("s1_done_cyc", 64'(done_cyc - st_cyc), 64'd7);
        chk("s1_perf", 64'(perf_cycles), 64'(exp_perf));

        // Three back-to-back words
        run_start(8'd3, 32'h44332211, 64'd0);
        send(8'h01); send(8'h02); send(8'h03);
        wait_done;
        chk("s2_count", 64'(log_res.size()), 64'd3);
        if (log_res.size() >= 3) begin
            chk("s2_col0_a", 64'(log_res[0][15:0]), 64'h0011);
            chk("s2_col0_b", 64'(log_res[1][15:0]), 64'h0022);
            chk("s2_col0_c", 64'(log_res[2][15:0]), 64'h0033);
            chk("s2_col3_c", 64'(log_res[2][63:48]), 64'h00CC);
            chk("s2_consec", 64'(log_cyc[2] - log_cyc[0]), 64'd2);
        end

        // Nonzero bias with 16-bit wrap in column 0
        run_start(8'd1, 32'h010203FF, 64'h0001_0010_0100_1000);
        send(8'hFF);
        wait_done;
        chk("s2b_count", 64'(log_res.size()), 64'd1);
        if (log_res.size() >= 1) chk("s2b_col0", 64'(log_res[0][15:0]), 64'h0E01);

        // Two words separated by a 3-cycle bubble
        run_start(8'd2, 32'h44332211, 64'd0);
        send(8'h05);
        repeat (3) step;
        send(8'h06);
        wait_done;
        chk("s3_count", 64'(log_res.size()), 64'd2);
        if (log_res.size() >= 2) begin
            chk("s3_gap", 64'(log_cyc[1] - log_cyc[0]), 64'd4);
            chk("s3_col0_b", 64'(log_res[1][15:0]), 64'h0066);
        end

        // Empty job
        run_start(8'd0, 32'h44332211, 64'd0);
        wait_done;
        chk("s4_count", 64'(log_res.size()), 64'd0);
        chk("s4_done_cyc", 64'(done_cyc - st_cyc), 64'd6);

        // Start during STREAM is ignored; original weights stay in effect
        run_start(8'd3, 32'h44332211, 64'd0);
        send(8'h01);
        len = 8'd1; weights = 32'h0A0A0A0A; start = 1'b1;
        step;
        start = 1'b0;
        send(8'h02); send(8'h03);
        wait_done;
        chk("s5_count", 64'(log_res.size()), 64'd3);
        if (log_res.size() >= 3) chk("s5_col0_c", 64'(log_res[2][15:0]), 64'h0033);

        // Reset mid-STREAM discards the job and its in-flight results
        run_start(8'd4, 32'h44332211, 64'h0005_0005_0005_0005);
        send(8'h07); send(8'h08);
        din = 8'h99; din_valid = 1'b1; rst_n = 1'b0;
        step;
        chk_all_zero("midrst");
        rst_n = 1'b1; din_valid = 1'b0; din = '0;
        log_res.delete(); log_cyc.delete();
        repeat (8) step;
        chk("midrst_no_res", 64'(log_res.size()), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule

// File: doc/sysrow_seq.md
SYSROW_SEQ -- requirements
Module: sysrow_seq

Interface
REQ-001 Parameter ROW_WIDTH, default 4: number of cells in the driven SysRow.
REQ-002 Parameter LEN_W, default 8: width of the vector-length field.
REQ-003 Ports, clock and reset first:
- clk  in  1  sole clock.
- rst_n  in  1  synchronous, active-low reset.
- start  in  1  begin one job (pulse).
- len  in  LEN_W  number of data words in the job.
- weights  in  8*ROW_WIDTH  packed weights, cell 0 at [7:0].
- bias  in  16*ROW_WIDTH  packed per-column sum_in.
- din  in  8  streamed data word.
- din_valid  in  1  din is valid.
- din_ready  out  1  sequencer accepts din.
- row_active  out  1  to SysRow active.
- row_data  out  8  to SysRow data_in.
- row_w  out  8*ROW_WIDTH  to SysRow w_in.
- row_wren  out  ROW_WIDTH  to SysRow weight_wren.
- row_sum  out  16*ROW_WIDTH  to SysRow sum_in.
- row_mac  in  16*ROW_WIDTH  from SysRow mac_out.
- res  out  16*ROW_WIDTH  deskewed result vector.
- res_valid  out  1  res is valid.
- busy  out  1  job in progress.
- done  out  1  one-cycle end-of-job pulse.
- perf_cycles  out  32  busy-cycle count.
REQ-004 Clock and reset: one clock, clk; reset is synchronous and active-low, rst_n.

Function
REQ-005 FSM states: IDLE, LOAD, STREAM, DRAIN, DONE.
REQ-006 Transitions:
- IDLE->LOAD on start; at that edge len, weights and bias are captured.
- LOAD->STREAM after exactly 1 cycle.
- STREAM->DRAIN on the cycle the len-th word transfers.
- DRAIN->DONE after ROW_WIDTH cycles.
- DONE->IDLE after 1 cycle.
REQ-007 In LOAD: row_wren = all ones and row_w = captured weights. In all other states row_wren = 0.
REQ-008 A data transfer occurs when din_valid && din_ready. din_ready = 1 only in STREAM while words remain.
REQ-009 On a transfer cycle: row_active = 1 and row_data = din. Otherwise row_active = 0 and row_data = 0. Bubbles (din_valid low) are permitted.
REQ-010 row_sum = captured bias throughout the job; 0 in IDLE.
REQ-011 Timing model: cell k's row_mac slice for the word transferred at cycle t is valid at cycle t+k+1.
REQ-012 Deskew: column k is delayed by ROW_WIDTH-1-k cycles. The full vector for word t appears on res with res_valid = 1 at cycle t+ROW_WIDTH. Results keep input order and preserve bubbles.
REQ-013 res has no backpressure; the consumer must accept every res_valid cycle.
REQ-014 busy = 1 in LOAD, STREAM, DRAIN, DONE. done = 1 only in DONE.
REQ-015 start while busy is ignored.
REQ-016 len = 0: LOAD->DRAIN directly; no transfers, no res_valid, done still pulses.
REQ-017 The remaining-word counter decrements only on transfers and never wraps below 0.
REQ-018 DRAIN lasts ROW_WIDTH cycles, so the last res_valid occurs within DRAIN, before done.

Reset
REQ-019 rst_n low at any edge, including mid-job, forces IDLE and sets these to 0:
- all outputs;
- counters and deskew/valid pipelines;
- captured registers.
Any in-flight results are discarded.

Configuration
REQ-020 Macro SYSROW_SEQ_PERF_EN:
- Defined: perf_cycles counts cycles with busy = 1, saturates at 2^32-1, and clears on start accepted from IDLE and on reset.
- Undefined: perf_cycles is tied to 0 and no counter logic exists.

Structure
REQ-021 Package sysrow_pkg holds:
- the state enum;
- constants DATA_W = 8 and SUM_W = 16;
- helper width functions.
REQ-022 One sub-module, sysrow_deskew, implements the per-column delay lines and the valid shift register of REQ-012. The FSM stays in sysrow_seq.

Verification
REQ-023 Bench pairs sysrow_seq with a SysRow instance, ROW_WIDTH = 4.
REQ-024 Scenarios:
- weights = 0x44332211, bias = 0, len = 1, din = 0x10 -> exactly one res_valid with res = {0x0440, 0x0330, 0x0220, 0x0110}; then done.
- len = 3, din 0x01, 0x02, 0x03 back-to-back, same weights -> three consecutive res_valid with column 0 = 0x0011, 0x0022, 0x0033.
- len = 2 with a 3-cycle din_valid gap -> res_valid pulses separated by the same gap; values correct.
- len = 0 -> no row_active, no res_valid; done occurs 1+ROW_WIDTH+1 cycles after start.
- start pulsed during STREAM -> ignored; rst_n low mid-STREAM -> next cycle all outputs 0 and state IDLE.
- SYSROW_SEQ_PERF_EN defined, len = 1, no bubbles -> perf_cycles = 7 after done (1 LOAD + 1 STREAM + 4 DRAIN + 1 DONE); undefined -> 0.
